// File: rtl/alu32.sv
// rtl/alu32.sv - 32-bit eight-function ALU with registered result and flags (optional c_out: ALU32_COUT_EN)
module alu32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        s2,
  input  logic        s1,
  input  logic        s0,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef ALU32_COUT_EN
  output logic        c_out,
`endif
  output logic [31:0] r,
  output logic        zero,
  output logic        overflow
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  logic [2:0]         op;
  logic [31:0]        sum;
  logic [31:0]        dif;
  logic signed [63:0] prod;
  logic               slt;
  logic [31:0]        res;
  logic               ovf;

  assign op = {s2, s1, s0};

`ifdef ALU32_COUT_EN
  logic add_c;
  logic sub_c;
  logic cout;
  // Carry out is a no-borrow indication for SUB (a + ~b + 1).
  assign {add_c, sum} = {1'b0, a} + {1'b0, b};
  assign {sub_c, dif} = {1'b0, a} + {1'b0, ~b} + 33'd1;
`else
  assign sum = a + b;
  assign dif = a - b;
`endif

  // Full signed 64-bit product; low half is the result, high half feeds overflow.
  assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // 33-bit compare so SLT stays correct when a-b would overflow.
  assign slt = $signed({a[31], a}) < $signed({b[31], b});

  // Select the function result and its signed-overflow flag.
  always_comb begin
    res = 32'h0;
    ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = sum;
        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_XOR:  res = a ^ b;
      OP_SUB: begin
        res = dif;
        ovf = (a[31] != b[31]) && (dif[31] != a[31]);
      end
      OP_MULT: begin
        res = prod[31:0];
        ovf = prod[63:32] != {32{prod[31]}};
      end
      OP_SLT:  res = {31'b0, slt};
      OP_NOR:  res = ~(a | b);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: begin
        res = 32'h0;
        ovf = 1'b0;
      end
    endcase
  end

`ifdef ALU32_COUT_EN
  // Carry is only meaningful for the adder paths.
  always_comb begin
    cout = 1'b0;
    if (op == OP_ADD)      cout = add_c;
    else if (op == OP_SUB) cout = sub_c;
  end

  // Register the carry alongside the result.
  always_ff @(posedge clk) begin
    if (reset) c_out <= 1'b0;
    else       c_out <= cout;
  end
`endif

  // Output register: one-cycle latency, reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r        <= 32'h0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      r        <= res;
      zero     <= (res == 32'h0);
      overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// tb/tb_alu32.sv - self-checking bench for alu32 (directed table, reset cases, random model)
module tb_alu32;

  logic        clk = 1'b0;
  logic        reset;
  logic        s2, s1, s0;
  logic [31:0] a, b;
  logic [31:0] r;
  logic        zero;
  logic        overflow;
`ifdef ALU32_COUT_EN
  logic        c_out;
`endif

  int n_pass = 0;
  int n_total = 0;

  alu32 dut (
    .clk      (clk),
    .reset    (reset),
    .s2       (s2),
    .s1       (s1),
    .s0       (s0),
    .a        (a),
    .b        (b),
`ifdef ALU32_COUT_EN
    .c_out    (c_out),
`endif
    .r        (r),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    {s2, s1, s0} = op;
    a = av;
    b = bv;
  endtask

  // Reference model from the arithmetic definitions, using wide signed integers.
  task automatic model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] rv, output logic zv, output logic vv, output logic cv);
    longint sa, sb, s;
    longint unsigned ua, ub;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = longint'(av);
    ub = longint'(bv);
    vv = 1'b0;
    cv = 1'b0;
    case (op)
      3'd0: begin
        s = sa + sb; rv = s[31:0];
        vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cv = ((ua + ub) >> 32) != 0;
      end
      3'd1: rv = av ^ bv;
      3'd2: begin
        s = sa - sb; rv = s[31:0];
        vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cv = (ua >= ub);
      end
      3'd3: begin
        s = sa * sb; rv = s[31:0];
        vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd4: rv = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: rv = ~(av | bv);
      3'd6: rv = av & bv;
      default: rv = av | bv;
    endcase
    zv = (rv == 32'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic        ez, ev, ec;
    logic [2:0]  op;
    logic [31:0] av, bv;

    tbl[0]  = '{3'd0, 32'h33333333, 32'h33333333, 32'h66666666, 1'b0, 1'b0};
    tbl[1]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    tbl[2]  = '{3'd0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tbl[3]  = '{3'd2, 32'h55555555, 32'h1D551D55, 32'h38003800, 1'b0, 1'b0};
    tbl[4]  = '{3'd2, 32'h55555555, 32'h55555555, 32'h00000000, 1'b1, 1'b0};
    tbl[5]  = '{3'd2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    tbl[6]  = '{3'd1, 32'hB3333333, 32'h33333333, 32'h80000000, 1'b0, 1'b0};
    tbl[7]  = '{3'd5, 32'hB3333333, 32'h33333333, 32'h4CCCCCCC, 1'b0, 1'b0};
    tbl[8]  = '{3'd6, 32'hBBF9D3FB, 32'hF1FF0F33, 32'hB1F90333, 1'b0, 1'b0};
    tbl[9]  = '{3'd7, 32'hAF31B203, 32'h33333733, 32'hBF33B733, 1'b0, 1'b0};
    tbl[10] = '{3'd4, 32'h00000333, 32'h33333333, 32'h00000001, 1'b0, 1'b0};
    tbl[11] = '{3'd4, 32'h55555555, 32'h1D551D55, 32'h00000000, 1'b1, 1'b0};
    tbl[12] = '{3'd4, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    tbl[13] = '{3'd3, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA, 1'b0, 1'b0};
    tbl[14] = '{3'd3, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1};

    // Reset with all-ones operands on ADD.
    reset = 1'b1;
    drive(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check("reset_r", r, 32'h0);
    check("reset_zero", {31'b0, zero}, 32'd1);
    check("reset_ovf", {31'b0, overflow}, 32'd0);
`ifdef ALU32_COUT_EN
    check("reset_cout", {31'b0, c_out}, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_r", r, 32'hFFFFFFFE);
    check("post_reset_ovf", {31'b0, overflow}, 32'd0);

    // Directed table, applied back to back.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      @(posedge clk); #1;
      check($sformatf("vec%0d_r", i), r, tbl[i].r);
      check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, tbl[i].z});
      check($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, tbl[i].v});
    end

    // Mid-stream reset discards the pending ADD.
    drive(3'd0, 32'h12345678, 32'h11111111);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_r", r, 32'h0);
    check("midreset_zero", {31'b0, zero}, 32'd1);
    reset = 1'b0;
    drive(3'd3, 32'h7FFFFFFF, 32'h7FFFFFFF);
    @(posedge clk); #1;
    check("after_midreset_r", r, 32'h00000001);
    check("after_midreset_ovf", {31'b0, overflow}, 32'd1);

    // Random back-to-back stream: each cycle's output reflects the previous inputs.
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      av = $urandom();
      bv = $urandom();
      if (i % 8 == 0) bv = av;
      if (i % 13 == 0) av = {av[31], 31'h7FFFFFFF ^ {31{av[31]}}};
      model(op, av, bv, er, ez, ev, ec);
      drive(op, av, bv);
      @(posedge clk); #1;
      check($sformatf("rnd%0d_op%0d_r", i, op), r, er);
      check($sformatf("rnd%0d_zero", i), {31'b0, zero}, {31'b0, ez});
      check($sformatf("rnd%0d_ovf", i), {31'b0, overflow}, {31'b0, ev});
`ifdef ALU32_COUT_EN
      check($sformatf("rnd%0d_cout", i), {31'b0, c_out}, {31'b0, ec});
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
